// File: rtl/adiabatic_pclk_gen.sv
// Four-phase adiabatic power-clock sequencer: two staggered stepped-level pairs,
// stage 2 lagging stage 1 by one phase, with period pulse and completed-period count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// STOPPED | outputs parked at rest levels, waiting for en
// RUN     | stepping p/k through RAMP_UP, HOLD, RAMP_DN, IDLE periods
module adiabatic_pclk_gen #(
    parameter int LEVEL_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [LEVEL_W-1:0] clkpos,
    output logic [LEVEL_W-1:0] clkneg,
    output logic [LEVEL_W-1:0] clkpos2,
    output logic [LEVEL_W-1:0] clkneg2,
    output logic [1:0]         phase,
    output logic [1:0]         phase2,
    output logic               running,
    output logic               period_done,
    output logic [CNT_W-1:0]   period_cnt
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_UP   = 2'd1;
    localparam logic [1:0] PH_HOLD = 2'd2;
    localparam logic [1:0] PH_DN   = 2'd3;

    localparam logic [LEVEL_W-1:0] LVL_M   = '1;
    localparam logic [LEVEL_W-1:0] LVL_ONE = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] K_LAST  = LVL_M - LVL_ONE;
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    state_t             state, state_nxt;
    logic [1:0]         p, p_nxt;
    logic [LEVEL_W-1:0] k, k_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic               running_d;
    logic               period_done_d;
    logic [1:0]         phase_d;
    logic [1:0]         phase2_d;
    logic [LEVEL_W-1:0] clkpos_d;
    logic [LEVEL_W-1:0] clkpos2_d;

    // Stepped level for a stage given its own phase and the shared step counter.
    function automatic logic [LEVEL_W-1:0] level_of(input logic [1:0] ph,
                                                    input logic [LEVEL_W-1:0] kk);
        logic [LEVEL_W-1:0] lvl;
        case (ph)
            PH_UP:   lvl = kk + LVL_ONE;
            PH_HOLD: lvl = LVL_M;
            PH_DN:   lvl = K_LAST - kk;
            default: lvl = '0;
        endcase
        return lvl;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_STOPPED;
            p           <= PH_IDLE;
            k           <= '0;
            period_cnt  <= '0;
            running     <= 1'b0;
            period_done <= 1'b0;
            phase       <= PH_IDLE;
            phase2      <= PH_IDLE;
            clkpos      <= '0;
            clkneg      <= LVL_M;
            clkpos2     <= '0;
            clkneg2     <= LVL_M;
        end else begin
            state       <= state_nxt;
            p           <= p_nxt;
            k           <= k_nxt;
            period_cnt  <= cnt_nxt;
            running     <= running_d;
            period_done <= period_done_d;
            phase       <= phase_d;
            phase2      <= phase2_d;
            clkpos      <= clkpos_d;
            clkneg      <= LVL_M - clkpos_d;
            clkpos2     <= clkpos2_d;
            clkneg2     <= LVL_M - clkpos2_d;
        end
    end

    // en only matters when stopped or at the last step of IDLE, so a period always drains.
    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        k_nxt     = k;
        cnt_nxt   = period_cnt;
        unique case (state)
            ST_STOPPED: begin
                p_nxt = PH_IDLE;
                k_nxt = '0;
                if (en) begin
                    state_nxt = ST_RUN;
                    p_nxt     = PH_UP;
                end
            end
            ST_RUN: begin
                if (k == K_LAST) begin
                    k_nxt = '0;
                    if (p == PH_IDLE) begin
                        cnt_nxt = period_cnt + CNT_ONE;
                        if (en) begin
                            p_nxt = PH_UP;
                        end else begin
                            state_nxt = ST_STOPPED;
                            p_nxt     = PH_IDLE;
                        end
                    end else begin
                        p_nxt = p + 2'd1;
                    end
                end else begin
                    k_nxt = k + LVL_ONE;
                end
            end
        endcase
    end

    // Outputs are derived from the next state so that they land in registers.
    always_comb begin
        running_d     = (state_nxt == ST_RUN);
        phase_d       = running_d ? p_nxt : PH_IDLE;
        phase2_d      = running_d ? (p_nxt - 2'd1) : PH_IDLE;
        clkpos_d      = running_d ? level_of(phase_d, k_nxt) : '0;
        clkpos2_d     = running_d ? level_of(phase2_d, k_nxt) : '0;
        period_done_d = running_d && (p_nxt == PH_IDLE) && (k_nxt == K_LAST);
    end

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Directed bench for adiabatic_pclk_gen (LEVEL_W = 3, M = 7); a second
// instance with a 2-bit period counter exercises counter wrap.
module tb_adiabatic_pclk_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       en2;
    logic [2:0] clkpos, clkneg, clkpos2, clkneg2;
    logic [1:0] phase, phase2;
    logic       running, period_done;
    logic [15:0] period_cnt;

    logic [2:0] w_clkpos, w_clkneg, w_clkpos2, w_clkneg2;
    logic [1:0] w_phase, w_phase2;
    logic       w_running, w_period_done;
    logic [1:0] w_period_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adiabatic_pclk_gen #(.LEVEL_W(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .clkpos(clkpos), .clkneg(clkneg), .clkpos2(clkpos2), .clkneg2(clkneg2),
        .phase(phase), .phase2(phase2), .running(running),
        .period_done(period_done), .period_cnt(period_cnt)
    );

    adiabatic_pclk_gen #(.LEVEL_W(3), .CNT_W(2)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en2),
        .clkpos(w_clkpos), .clkneg(w_clkneg), .clkpos2(w_clkpos2), .clkneg2(w_clkneg2),
        .phase(w_phase), .phase2(w_phase2), .running(w_running),
        .period_done(w_period_done), .period_cnt(w_period_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stage-1 level for cycle c (0..27) of a period: 1..7, 7x7, 6..0, 0x7.
    function automatic int exp_pos(input int c);
        if (c < 7)       return c + 1;
        else if (c < 14) return 7;
        else if (c < 21) return 20 - c;
        else             return 0;
    endfunction

    function automatic int exp_pos2(input int c);
        return (c < 7) ? 0 : exp_pos(c - 7);
    endfunction

    function automatic int exp_phase(input int c);
        if (c < 7)       return 1;
        else if (c < 14) return 2;
        else if (c < 21) return 3;
        else             return 0;
    endfunction

    task automatic check_cycle(input int c);
        check("clkpos",      clkpos,      exp_pos(c));
        check("clkneg",      clkneg,      7 - exp_pos(c));
        check("clkpos2",     clkpos2,     exp_pos2(c));
        check("clkneg2",     clkneg2,     7 - exp_pos2(c));
        check("phase",       phase,       exp_phase(c));
        check("phase2",      phase2,      (exp_phase(c) + 3) % 4);
        check("running",     running,     1);
        check("period_done", period_done, (c == 27) ? 1 : 0);
    endtask

    task automatic check_stopped(input int cnt);
        check("stop_clkpos",  clkpos,      0);
        check("stop_clkneg",  clkneg,      7);
        check("stop_clkpos2", clkpos2,     0);
        check("stop_clkneg2", clkneg2,     7);
        check("stop_phase",   phase,       0);
        check("stop_phase2",  phase2,      0);
        check("stop_running", running,     0);
        check("stop_done",    period_done, 0);
        check("stop_cnt",     period_cnt,  cnt);
    endtask

    int exp_wrap[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        en2   = 1'b0;
        repeat (3) step();
        check_stopped(0);

        en    = 1'b0;
        rst_n = 1'b1;
        step();
        check_stopped(0);

        // single period from a one-cycle en pulse
        en = 1'b1;
        step();
        en = 1'b0;
        for (int c = 0; c < 28; c++) begin
            check_cycle(c);
            step();
        end
        check_stopped(1);
        step();
        check_stopped(1);

        // three back-to-back periods
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        step();
        for (int c = 0; c < 84; c++) begin
            check("cont_clkpos", clkpos, exp_pos(c % 28));
            check("cont_sum", int'(clkpos) + int'(clkneg), 7);
            check("cont_done", period_done, (c % 28 == 27) ? 1 : 0);
            if (c == 83) en = 1'b0;
            step();
        end
        check_stopped(3);

        // en dropped and toggled mid-period: full period still runs out
        en = 1'b1;
        step();
        for (int c = 0; c < 28; c++) begin
            check_cycle(c);
            if (c == 10) en = 1'b0;
            if (c == 15) en = 1'b1;
            if (c == 16) en = 1'b0;
            step();
        end
        check_stopped(4);

        // asynchronous reset in the middle of RAMP_DN
        en = 1'b1;
        step();
        en = 1'b0;
        for (int c = 0; c < 15; c++) step();
        check("mid_clkpos", clkpos, 5);
        rst_n = 1'b0;
        #1;
        check_stopped(0);
        #2;
        rst_n = 1'b1;
        en = 1'b1;
        step();
        en = 1'b0;
        check("restart_clkpos",  clkpos,  1);
        check("restart_clkpos2", clkpos2, 0);
        check("restart_running", running, 1);
        check("restart_cnt",     period_cnt, 0);
        repeat (28) step();
        check_stopped(1);

        // 2-bit counter wraps over five periods
        en2 = 1'b1;
        step();
        for (int c = 0; c < 140; c++) begin
            if (c >= 28 && c % 28 == 0)
                check("wrap_cnt", w_period_cnt, exp_wrap[c / 28 - 1]);
            if (c == 139) en2 = 1'b0;
            step();
        end
        check("wrap_cnt_final", w_period_cnt, exp_wrap[4]);
        check("wrap_running",   w_running,    0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adiabatic_pclk_gen.md
Name: adiabatic_pclk_gen

Overview:
Digital sequencer that generates the two staggered four-phase power-clock pairs (clkpos/clkneg, clkpos2/clkneg2) consumed by the adiabatic gate cells. Each power clock is emitted as a stepped level code for the downstream charge-recovery driver/DAC. The second pair lags the first by exactly one phase, so stage-1 outputs hold while stage-2 gates evaluate.

Parameters:
LEVEL_W, 3, width of level codes; M = 2^LEVEL_W - 1 is full-rail code and also cycles per phase
CNT_W, 16, width of completed-period counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  run request, level-sensitive
clkpos  output  LEVEL_W  stage-1 positive power-clock level
clkneg  output  LEVEL_W  stage-1 negative power-clock level, always M - clkpos
clkpos2  output  LEVEL_W  stage-2 positive power-clock level
clkneg2  output  LEVEL_W  stage-2 negative power-clock level, always M - clkpos2
phase  output  2  stage-1 phase: 0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DN
phase2  output  2  stage-2 phase, always (phase - 1) mod 4 while running, 0 when stopped
running  output  1  high in RUN state
period_done  output  1  one-cycle pulse on last cycle of each full period
period_cnt  output  CNT_W  count of completed periods, wraps

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All outputs are registered.
- Reset values: state STOPPED; clkpos = clkpos2 = 0; clkneg = clkneg2 = M; phase = phase2 = 0; running = 0; period_done = 0; period_cnt = 0; step counter k = 0.
- Reset asserted mid-period forces reset values immediately. No ramp-down is performed.
- FSM has two states, STOPPED and RUN. Internal state is p (stage-1 phase, 2 bits) and k (step within phase, 0..M-1).
- STOPPED: outputs at reset levels, period_cnt retained. At a clk edge with en = 1, the next state is RUN with p = RAMP_UP and k = 0, so clkpos = 1 in the first cycle after en is sampled.
- RUN: k increments every cycle. At k = M-1, k wraps to 0 and p advances IDLE→RAMP_UP→HOLD→RAMP_DN→IDLE.
- Level mapping, applied to a stage's own phase and to k:
  - IDLE: 0
  - RAMP_UP: k+1 (1..M)
  - HOLD: M
  - RAMP_DN: M-1-k (M-1..0)
- The level changes by at most 1 code per cycle, except at reset.
- Stage 2 uses phase (p-1) mod 4 with the same k. During stage-1's first RAMP_UP after a start, stage 2 is IDLE.
- Period length is 4M cycles. Stage 2 finishes RAMP_DN on the same cycle that stage 1 finishes IDLE.
- End of period (p = IDLE, k = M-1):
  - period_done = 1 for that cycle.
  - period_cnt increments by 1, mod 2^CNT_W.
  - en is sampled on this edge: en = 1 → p = RAMP_UP, k = 0, period continues seamlessly; en = 0 → STOPPED.
- en is ignored at all other points in RUN. Deasserting en mid-period always completes the full period, so both stages drain to 0.
- en toggling within a period has no effect; only the end-of-period sample matters.
- running stays 1 through the final period, including the cycle with period_done.

Test Plan:
- Reset: hold rst_n = 0 with en = 1 → clkpos = 0, clkneg = 7, clkpos2 = 0, clkneg2 = 7, running = 0, period_cnt = 0 (LEVEL_W = 3, M = 7).
- Single period: en high for one cycle from STOPPED →
  - clkpos over cycles 0..27: 1..7, 7×7, 6..0, 0×7.
  - clkpos2: 0×7, 1..7, 7×7, 6..0.
  - period_done at cycle 27, period_cnt = 1, STOPPED at cycle 28.
- Continuous run: en held high for 3 periods → period_done at cycles 27, 55, 83; clkpos = 1 at cycles 28 and 56; period_cnt = 3. Check clkneg + clkpos = 7 every cycle.
- Mid-period stop: drop en at cycle 10 → outputs follow the full 28-cycle pattern, running falls at cycle 28, no truncated ramp.
- Reset mid-operation: assert rst_n = 0 at cycle 15 (clkpos = 5) → same-cycle asynchronous return to reset values. Restart with en = 1 → clkpos = 1 one cycle after en is sampled.
- Wrap: CNT_W = 2, run 5 periods → period_cnt sequence 1, 2, 3, 0, 1.
